line_cmd_arbiter: RTL and testbench
===================================

Name: line_cmd_arbiter

Overview:
- Shares one line-draw engine between NREQ requesters (rasteriser front-ends, UI overlay, debug path).
- Arbitrates round-robin, latches the winner's endpoint coordinates and drives them to the engine.
- Pulses the engine's update input and tracks its busy output through the draw.
- Returns a per-requester done pulse, or an error pulse if the engine never starts.

Parameters:
NREQ, 4, number of requesters (1..16)
W, 16, coordinate width in bits
START_TIMEOUT, 15, max cycles after update pulse to wait for eng_busy to rise (1..255)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  synchronous active-low reset
req_valid  in  NREQ  bit i: requester i has a command pending
req_ready  out  NREQ  bit i: command i accepted this cycle (one-hot or zero)
req_x0  in  NREQ*W  packed, requester i at [i*W +: W]; same packing for req_x1, req_y0, req_y1
req_x1  in  NREQ*W  endpoint 1 x
req_y0  in  NREQ*W  endpoint 0 y
req_y1  in  NREQ*W  endpoint 1 y
done  out  NREQ  one-cycle pulse on bit of owner when its line completes or times out
err  out  NREQ  one-cycle pulse, coincident with done, on start timeout
eng_update  out  1  one-cycle start pulse to engine
eng_busy  in  1  engine busy
eng_x0, eng_x1, eng_y0, eng_y1  out  W each  registered coordinates to engine
grant_id  out  clog2(NREQ) (min 1)  index of current/last owner
ctrl_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, rr pointer=0, grant_id=0, eng_x0/x1/y0/y1=0, eng_update=0, req_ready=0, done=0, err=0, timer=0. Reset mid-draw aborts tracking; no done is issued for the aborted command; the engine itself is not reset by this block.
- States: IDLE, ISSUE, WAIT_BUSY, DRAWING, DONE.
- IDLE: grant only if some req_valid=1 AND eng_busy=0. Winner = first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping NREQ-1 -> 0.
  - Grant cycle: req_ready[winner]=1 (combinational from state, valid, ptr, eng_busy). This is the handshake cycle.
  - Grant cycle: winner's coordinates registered into eng_*, grant_id<=winner, next state ISSUE.
- ISSUE: eng_update=1 for exactly this cycle; timer<=0; next state WAIT_BUSY.
- WAIT_BUSY:
  - eng_busy=1 -> DRAWING.
  - Else timer++; when timer reaches START_TIMEOUT-1 with eng_busy still 0 -> DONE with timeout flag set.
  - eng_busy=1 on the limit cycle wins (-> DRAWING, no error).
- DRAWING: eng_busy=0 -> DONE; otherwise stay (no draw-length limit).
- DONE: done[grant_id]=1, err[grant_id]=timeout flag, for one cycle; ptr<=(grant_id+1) mod NREQ; clear flag; next state IDLE.
- eng_* coordinates hold stable from the cycle after the grant until the next grant. Only an accepted command changes them.
- Requesters must hold valid and coordinates stable until ready. Dropping valid before grant is legal and ignored.
- A requester may re-assert valid in its own DONE cycle; it is considered in the next IDLE cycle at lowest priority.
- Minimum grant-to-done latency: 4 cycles (grant, ISSUE, WAIT_BUSY with busy already high, DRAWING with busy low, then DONE pulse) for a 1-cycle engine busy.
- NREQ=1: pointer is constant 0; otherwise identical behaviour.
- No command queueing: at most one command owned at a time; req_ready is never asserted outside IDLE.

Test Plan:
- Single request: req 2 valid, coords (10,20)->(300,40); engine model raises busy 1 cycle after update, busy 8 cycles -> req_ready[2] one cycle; eng_update one cycle later; eng_x0=10, eng_y1=40; done[2] one cycle after busy falls; err=0.
- Round-robin: all 4 valid continuously, ptr=0 after reset -> grant order 0,1,2,3,0; each done precedes the next ready; no requester granted twice before the others.
- Start timeout: engine never asserts busy, START_TIMEOUT=15 -> done[i] and err[i] pulse together 16 cycles after eng_update; next grant proceeds normally.
- Busy at limit: busy rises on the exact timeout cycle -> DRAWING entered, err stays 0.
- Engine busy in IDLE: eng_busy held 1 externally with req 0 valid -> no req_ready until busy drops, then grant on the same cycle.
- Reset mid-draw: rst_n=0 during DRAWING -> next cycle all outputs 0, state IDLE, no done pulse for the aborted owner; after release, the pending request re-arbitrates from ptr=0.

Source files
------------

// File: rtl/line_cmd_if.sv
// Requester / line-engine bundle for line_cmd_arbiter.
// master: the arbiter side. slave: requesters plus engine (environment side).
interface line_cmd_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x0;
  logic [NREQ*W-1:0] req_x1;
  logic [NREQ*W-1:0] req_y0;
  logic [NREQ*W-1:0] req_y1;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   err;
  logic              eng_update;
  logic              eng_busy;
  logic [W-1:0]      eng_x0;
  logic [W-1:0]      eng_x1;
  logic [W-1:0]      eng_y0;
  logic [W-1:0]      eng_y1;
  logic [IDW-1:0]    grant_id;
  logic              ctrl_busy;

  modport master (
    input  req_valid, req_x0, req_x1, req_y0, req_y1, eng_busy,
    output req_ready, done, err, eng_update, eng_x0, eng_x1, eng_y0, eng_y1,
           grant_id, ctrl_busy
  );

  modport slave (
    output req_valid, req_x0, req_x1, req_y0, req_y1, eng_busy,
    input  req_ready, done, err, eng_update, eng_x0, eng_x1, eng_y0, eng_y1,
           grant_id, ctrl_busy
  );
endinterface

// File: rtl/line_cmd_arbiter.sv
// Round-robin arbiter sharing one line-draw engine between NREQ requesters.
// Latches the winner's endpoints, pulses eng_update, follows eng_busy and
// returns a done (and, on a start timeout, err) pulse to the owner.
module line_cmd_arbiter #(
  parameter int NREQ          = 4,
  parameter int W             = 16,
  parameter int START_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  line_cmd_if.master bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] TLIM = 8'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, DRAWING, DONE} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gid;
  logic [7:0]     timer;
  logic           to_flag;
  logic [W-1:0]   ex0, ex1, ey0, ey1;

  logic [IDW-1:0] win;
  logic           grant;
  logic [NREQ-1:0] ready_c, done_c, err_c;
  logic           update_c;

  // First valid requester searching from p upward with wrap-around.
  // Scans in reverse search order so the earliest candidate is the last written.
  function automatic logic [IDW-1:0] rr_winner(input logic [NREQ-1:0] v,
                                               input logic [IDW-1:0]  p);
    logic [IDW-1:0] w;
    logic [IDW:0]   sum;
    w = p;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, p} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      if (v[sum[IDW-1:0]]) w = sum[IDW-1:0];
    end
    return w;
  endfunction

  assign win   = rr_winner(bus.req_valid, ptr);
  // A grant is suppressed while reset is asserted so no phantom handshake occurs.
  assign grant = rst_n && (state == IDLE) && (|bus.req_valid) && !bus.eng_busy;

  // Next-state and per-cycle control outputs.
  always_comb begin
    state_nxt = state;
    ready_c   = '0;
    done_c    = '0;
    err_c     = '0;
    update_c  = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          ready_c[win] = 1'b1;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        update_c  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.eng_busy)        state_nxt = DRAWING;
        else if (timer == TLIM)  state_nxt = DONE;
      end
      DRAWING: begin
        if (!bus.eng_busy) state_nxt = DONE;
      end
      DONE: begin
        done_c[gid] = 1'b1;
        err_c[gid]  = to_flag;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, round-robin pointer, start timer and latched engine coordinates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      gid     <= '0;
      timer   <= '0;
      to_flag <= 1'b0;
      ex0     <= '0;
      ex1     <= '0;
      ey0     <= '0;
      ey1     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant) begin
            ex0 <= bus.req_x0[win*W +: W];
            ex1 <= bus.req_x1[win*W +: W];
            ey0 <= bus.req_y0[win*W +: W];
            ey1 <= bus.req_y1[win*W +: W];
            gid <= win;
          end
        end
        ISSUE: timer <= '0;
        WAIT_BUSY: begin
          if (!bus.eng_busy) begin
            if (timer == TLIM) to_flag <= 1'b1;
            else               timer   <= timer + 8'd1;
          end
        end
        DONE: begin
          ptr     <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
          to_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.done       = done_c;
  assign bus.err        = err_c;
  assign bus.eng_update = update_c;
  assign bus.eng_x0     = ex0;
  assign bus.eng_x1     = ex1;
  assign bus.eng_y0     = ey0;
  assign bus.eng_y1     = ey1;
  assign bus.grant_id   = gid;
  assign bus.ctrl_busy  = (state != IDLE);
endmodule

// File: tb/tb_line_cmd_arbiter.sv
// Scoreboard bench for line_cmd_arbiter with a behavioural line engine.
module tb_line_cmd_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int ST   = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_cmd_if #(.NREQ(NREQ), .W(W)) bus ();

  line_cmd_arbiter #(.NREQ(NREQ), .W(W), .START_TIMEOUT(ST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // requester stimulus
  logic [NREQ-1:0] valid_r = '0;
  logic [W-1:0] cx0 [NREQ];
  logic [W-1:0] cx1 [NREQ];
  logic [W-1:0] cy0 [NREQ];
  logic [W-1:0] cy1 [NREQ];
  logic [NREQ*W-1:0] px0, px1, py0, py1;
  logic persist = 1'b0;

  always_comb begin
    px0 = '0; px1 = '0; py0 = '0; py1 = '0;
    for (int i = 0; i < NREQ; i++) begin
      px0[i*W +: W] = cx0[i];
      px1[i*W +: W] = cx1[i];
      py0[i*W +: W] = cy0[i];
      py1[i*W +: W] = cy1[i];
    end
  end
  assign bus.req_valid = valid_r;
  assign bus.req_x0 = px0;
  assign bus.req_x1 = px1;
  assign bus.req_y0 = py0;
  assign bus.req_y1 = py1;

  // engine model: busy rises eng_dly cycles after update, lasts eng_len cycles
  logic busy_m = 1'b0;
  logic busy_force = 1'b0;
  logic eng_dead = 1'b0;
  int   eng_dly = 1;
  int   eng_len = 8;
  assign bus.eng_busy = busy_m | busy_force;

  always begin
    @(negedge clk);
    if (bus.eng_update === 1'b1 && !eng_dead) begin
      repeat (eng_dly) @(negedge clk);
      busy_m = 1'b1;
      repeat (eng_len) @(negedge clk);
      busy_m = 1'b0;
    end
  end

  // checking
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int           id;
    logic [W-1:0] x0, x1, y0, y1;
    logic         err;
    int           lat;
  } exp_t;

  exp_t q[$];
  int   order[$];
  logic owner = 1'b0;
  int   ptr_m = 0;
  logic in_rst = 1'b1;
  int   cyc = 0;
  int   grant_cyc = 0;
  int   upd_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // monitor: compares every cycle against the model, mid low phase
  always begin
    logic [NREQ-1:0] exp_rdy;
    int   wi;
    exp_t e;
    @(negedge clk);
    #2;
    if (!in_rst) begin
      exp_rdy = '0;
      wi = -1;
      if (!owner && !bus.eng_busy && (|valid_r)) begin
        wi = rr_pick(valid_r, ptr_m);
        exp_rdy[wi] = 1'b1;
      end
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("ctrl_busy", bus.ctrl_busy, owner);

      if (bus.eng_update) begin
        if (q.size() == 0) chk("update_unexpected", 1, 0);
        else begin
          chk("upd_x0", bus.eng_x0, q[0].x0);
          chk("upd_x1", bus.eng_x1, q[0].x1);
          chk("upd_y0", bus.eng_y0, q[0].y0);
          chk("upd_y1", bus.eng_y1, q[0].y1);
          chk("upd_lat", cyc - grant_cyc, 1);
          upd_cyc = cyc;
        end
      end

      if (|bus.done) begin
        if (q.size() == 0) chk("done_unexpected", bus.done, 0);
        else begin
          e = q.pop_front();
          chk("done_vec", bus.done, NREQ'(1) << e.id);
          chk("err_vec", bus.err, e.err ? (NREQ'(1) << e.id) : '0);
          chk("grant_id", bus.grant_id, e.id);
          chk("done_lat", cyc - upd_cyc, e.lat);
          owner = 1'b0;
          ptr_m = (e.id + 1) % NREQ;
        end
      end else begin
        chk("err_nodone", bus.err, 0);
      end

      if (wi >= 0) begin
        e.id = wi;
        e.x0 = cx0[wi]; e.x1 = cx1[wi]; e.y0 = cy0[wi]; e.y1 = cy1[wi];
        e.err = eng_dead;
        e.lat = eng_dead ? ST + 1 : eng_dly + eng_len + 1;
        q.push_back(e);
        order.push_back(wi);
        owner = 1'b1;
        grant_cyc = cyc;
        @(posedge clk);
        #1;
        if (persist) begin
          cx0[wi] = W'($urandom); cx1[wi] = W'($urandom);
          cy0[wi] = W'($urandom); cy1[wi] = W'($urandom);
        end else begin
          valid_r[wi] = 1'b0;
        end
      end
    end
  end

  task automatic do_reset(input int hold);
    @(negedge clk);
    in_rst = 1'b1;
    rst_n  = 1'b0;
    q.delete();
    owner = 1'b0;
    ptr_m = 0;
    @(posedge clk);
    #1;
    chk("rst_ctrl_busy", bus.ctrl_busy, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_update", bus.eng_update, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_coords", {bus.eng_x0, bus.eng_x1, bus.eng_y0, bus.eng_y1}, 0);
    repeat (hold) @(negedge clk);
    rst_n  = 1'b1;
    in_rst = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #3;
      if (valid_r == '0 && !owner && q.size() == 0) ok = 1'b1;
    end
    chk(tag, ok, 1'b1);
  endtask

  task automatic set_req(input int i, input int x0, input int y0, input int x1, input int y1);
    cx0[i] = W'(x0); cy0[i] = W'(y0); cx1[i] = W'(x1); cy1[i] = W'(y1);
    valid_r[i] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      cx0[i] = '0; cx1[i] = '0; cy0[i] = '0; cy1[i] = '0;
    end
    do_reset(2);

    // single request from requester 2
    @(negedge clk);
    set_req(2, 10, 20, 300, 40);
    wait_quiet("single_quiet", 100);
    chk("hold_x0", bus.eng_x0, 10);
    chk("hold_y1", bus.eng_y1, 40);

    // round-robin with all requesters continuously valid
    do_reset(1);
    order.delete();
    @(negedge clk);
    persist = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 100 + i, 200 + i, 300 + i, 400 + i);
    for (int i = 0; i < 1000 && order.size() < 5; i++) @(negedge clk);
    persist = 1'b0;
    chk("rr_count", order.size() >= 5, 1);
    if (order.size() >= 5) begin
      chk("rr_0", order[0], 0);
      chk("rr_1", order[1], 1);
      chk("rr_2", order[2], 2);
      chk("rr_3", order[3], 3);
      chk("rr_4", order[4], 0);
    end
    wait_quiet("rr_quiet", 400);

    // start timeout, then a normal draw
    @(negedge clk);
    eng_dead = 1'b1;
    set_req(1, 5, 6, 7, 8);
    wait_quiet("timeout_quiet", 100);
    @(negedge clk);
    eng_dead = 1'b0;
    set_req(1, 9, 10, 11, 12);
    wait_quiet("after_timeout_quiet", 100);

    // busy rises on the last allowed wait cycle
    @(negedge clk);
    eng_dly = ST;
    eng_len = 3;
    set_req(3, 1000, 2000, 3000, 4000);
    wait_quiet("limit_quiet", 100);
    eng_dly = 1;

    // engine busy externally while idle
    @(negedge clk);
    busy_force = 1'b1;
    set_req(0, 77, 88, 99, 111);
    repeat (6) @(negedge clk);
    busy_force = 1'b0;
    wait_quiet("busy_idle_quiet", 100);

    // reset in the middle of a draw (pointer is 1 here)
    @(negedge clk);
    eng_len = 20;
    set_req(1, 1, 2, 3, 4);
    for (int i = 0; i < 50 && !bus.eng_busy; i++) @(negedge clk);
    chk("mid_busy_seen", bus.eng_busy, 1);
    repeat (2) @(negedge clk);
    set_req(0, 21, 22, 23, 24);
    set_req(3, 31, 32, 33, 34);
    do_reset(2);
    eng_len = 4;
    order.delete();
    wait_quiet("post_rst_quiet", 200);
    chk("post_rst_grants", order.size(), 2);
    if (order.size() >= 1) chk("post_rst_first", order[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
